hazard_stall_unit: RTL and testbench

- Hazard detection and stall controller for the 5-stage pipeline with a 4-cycle multiplier in EX.
- Sits directly upstream of the forwarding unit and controls which instructions reach ID/EX and EX/MEM.
- Handles two hazards that forwarding cannot resolve:
  - load-use: one bubble;
  - multi-cycle multiply: EX holds the multiply for MULT_LATENCY cycles.
- Honours branch flushes and keeps a saturating stall-cycle counter.

---
 rtl/hazard_stall_unit_if.sv | 46 ++++
 rtl/hazard_stall_unit.sv | 152 +++++++++++++++
 tb/tb_hazard_stall_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit_if
// Bundles the pipeline-side signals of the hazard/stall controller.
//   Pipeline -> controller : rs1_IF_ID, rs2_IF_ID, uses_rs1_IF_ID,
//                            uses_rs2_IF_ID, rd_ID_EX, mem_read_ID_EX,
//                            mult_ID_EX, flush_EX_MEM
//   Controller -> pipeline : pc_write, if_id_write, id_ex_write, id_ex_bubble,
//                            ex_mem_bubble, mult_busy, mult_result_valid,
//                            stall_cycles[CNT_W-1:0]
// master = pipeline side, slave = the hazard controller.
// CNT_W must match the CNT_W of the attached hazard_stall_unit.
// -----------------------------------------------------------------------------
interface hazard_stall_unit_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       rs1_IF_ID;
   logic [4:0]       rs2_IF_ID;
   logic             uses_rs1_IF_ID;
   logic             uses_rs2_IF_ID;
   logic [4:0]       rd_ID_EX;
   logic             mem_read_ID_EX;
   logic             mult_ID_EX;
   logic             flush_EX_MEM;
   logic             pc_write;
   logic             if_id_write;
   logic             id_ex_write;
   logic             id_ex_bubble;
   logic             ex_mem_bubble;
   logic             mult_busy;
   logic             mult_result_valid;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output rs1_IF_ID, rs2_IF_ID, uses_rs1_IF_ID, uses_rs2_IF_ID,
             rd_ID_EX, mem_read_ID_EX, mult_ID_EX, flush_EX_MEM,
      input  pc_write, if_id_write, id_ex_write, id_ex_bubble,
             ex_mem_bubble, mult_busy, mult_result_valid, stall_cycles
   );

   modport slave (
      input  rs1_IF_ID, rs2_IF_ID, uses_rs1_IF_ID, uses_rs2_IF_ID,
             rd_ID_EX, mem_read_ID_EX, mult_ID_EX, flush_EX_MEM,
      output pc_write, if_id_write, id_ex_write, id_ex_bubble,
             ex_mem_bubble, mult_busy, mult_result_valid, stall_cycles
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Hazard detection / stall controller for a 5-stage pipeline whose EX stage
// hosts a MULT_LATENCY-cycle multiplier. Resolves load-use (one bubble) and
// multiply occupancy (MULT_LATENCY-1 stall cycles), honours branch flushes and
// keeps a saturating count of cycles with the PC frozen.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   hz   - hazard_stall_unit_if.slave (ID/EX operand info in, stage enables,
//          bubbles, multiply status and stall_cycles out)
// All outputs except stall_cycles are combinational from state + inputs.
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
   parameter int MULT_LATENCY = 4,
   parameter int CNT_W        = 32
) (
   input  logic               clk,
   input  logic               rst,
   hazard_stall_unit_if.slave hz
);
   localparam int CW = $clog2(MULT_LATENCY) + 1;
   localparam logic [CW-1:0]    LAST_CNT = CW'(MULT_LATENCY - 1);
   localparam logic [CNT_W-1:0] SAT_VAL  = {CNT_W{1'b1}};
   localparam logic             MULT_STALLS = (MULT_LATENCY > 1);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic load_use_s, mult_start_s, mult_last_s, mult_stall_s;
   logic pc_write_s, if_id_write_s, id_ex_write_s;
   logic id_ex_bubble_s, ex_mem_bubble_s, mult_busy_s, mult_valid_s;

   // Hazard conditions decoded from current state and ID/EX operands.
   always_comb begin
      load_use_s = 1'b0;
      if (hz.mem_read_ID_EX && (hz.rd_ID_EX != 5'd0) &&
          ((hz.uses_rs1_IF_ID && (hz.rs1_IF_ID == hz.rd_ID_EX)) ||
           (hz.uses_rs2_IF_ID && (hz.rs2_IF_ID == hz.rd_ID_EX)))) begin
         load_use_s = 1'b1;
      end else begin
         load_use_s = 1'b0;
      end
      // A multiply only starts from IDLE, so the old multiply still sitting
      // in EX during its release cycle can never re-trigger.
      mult_start_s = (state_q == S_IDLE) && hz.mult_ID_EX && MULT_STALLS;
      mult_last_s  = (state_q == S_BUSY) && (cnt_q == LAST_CNT);
      mult_stall_s = mult_start_s || ((state_q == S_BUSY) && !mult_last_s);
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= {CW{1'b0}};
         stall_q <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   // Next-state logic of the multiply sequencer and the stall counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (hz.flush_EX_MEM) begin
         state_d = S_IDLE;
         cnt_d   = {CW{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mult_start_s) begin
                  state_d = S_BUSY;
                  cnt_d   = CW'(1);
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = {CW{1'b0}};
               end
            end
            S_BUSY: begin
               if (mult_last_s) begin
                  state_d = S_IDLE;
                  cnt_d   = {CW{1'b0}};
               end else begin
                  state_d = S_BUSY;
                  cnt_d   = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = {CW{1'b0}};
            end
         endcase
      end
      if (!pc_write_s && (stall_q != SAT_VAL)) begin
         stall_d = stall_q + CNT_W'(1);
      end else begin
         stall_d = stall_q;
      end
   end

   // Output decode, priority: reset, flush, multiply stall, load-use, normal.
   always_comb begin
      pc_write_s      = 1'b1;
      if_id_write_s   = 1'b1;
      id_ex_write_s   = 1'b1;
      id_ex_bubble_s  = 1'b0;
      ex_mem_bubble_s = 1'b0;
      mult_valid_s    = 1'b0;
      mult_busy_s     = 1'b0;
      if (rst) begin
         mult_busy_s = 1'b0;
      end else begin
         mult_busy_s = (state_q == S_BUSY);
         if (hz.flush_EX_MEM) begin
            id_ex_bubble_s  = 1'b1;
            ex_mem_bubble_s = 1'b1;
         end else if (mult_stall_s) begin
            pc_write_s      = 1'b0;
            if_id_write_s   = 1'b0;
            id_ex_write_s   = 1'b0;
            ex_mem_bubble_s = 1'b1;
         end else if (mult_last_s) begin
            mult_valid_s = 1'b1;
         end else if (!MULT_STALLS && hz.mult_ID_EX) begin
            // Single-cycle multiplier: result is ready in its only EX cycle.
            mult_valid_s = 1'b1;
         end else if ((state_q == S_IDLE) && load_use_s) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_bubble_s = 1'b1;
         end else begin
            mult_valid_s = 1'b0;
         end
      end
   end

   assign hz.pc_write          = pc_write_s;
   assign hz.if_id_write       = if_id_write_s;
   assign hz.id_ex_write       = id_ex_write_s;
   assign hz.id_ex_bubble      = id_ex_bubble_s;
   assign hz.ex_mem_bubble     = ex_mem_bubble_s;
   assign hz.mult_busy         = mult_busy_s;
   assign hz.mult_result_valid = mult_valid_s;
   // The counter reads as zero for the whole time reset is held.
   assign hz.stall_cycles      = rst ? {CNT_W{1'b0}} : stall_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
// Three controllers (latency 4 / 32-bit counter, latency 2 / 4-bit counter,
// latency 1 / 8-bit counter) share one stimulus stream. A per-instance model
// tracks how many EX cycles the current multiply has spent and compares every
// output on each falling edge; directed phases add literal expectations.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
   logic u1 = 1'b0, u2 = 1'b0, mrd = 1'b0, mul = 1'b0, flush = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hazard_stall_unit_if #(.CNT_W(32)) ia ();
   hazard_stall_unit_if #(.CNT_W(4))  ib ();
   hazard_stall_unit_if #(.CNT_W(8))  ic ();

   hazard_stall_unit #(.MULT_LATENCY(4), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .hz(ia));
   hazard_stall_unit #(.MULT_LATENCY(2), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .hz(ib));
   hazard_stall_unit #(.MULT_LATENCY(1), .CNT_W(8))  dut_c (.clk(clk), .rst(rst), .hz(ic));

   assign ia.rs1_IF_ID = rs1; assign ia.rs2_IF_ID = rs2; assign ia.rd_ID_EX = rd;
   assign ia.uses_rs1_IF_ID = u1; assign ia.uses_rs2_IF_ID = u2;
   assign ia.mem_read_ID_EX = mrd; assign ia.mult_ID_EX = mul; assign ia.flush_EX_MEM = flush;
   assign ib.rs1_IF_ID = rs1; assign ib.rs2_IF_ID = rs2; assign ib.rd_ID_EX = rd;
   assign ib.uses_rs1_IF_ID = u1; assign ib.uses_rs2_IF_ID = u2;
   assign ib.mem_read_ID_EX = mrd; assign ib.mult_ID_EX = mul; assign ib.flush_EX_MEM = flush;
   assign ic.rs1_IF_ID = rs1; assign ic.rs2_IF_ID = rs2; assign ic.rd_ID_EX = rd;
   assign ic.uses_rs1_IF_ID = u1; assign ic.uses_rs2_IF_ID = u2;
   assign ic.mem_read_ID_EX = mrd; assign ic.mult_ID_EX = mul; assign ic.flush_EX_MEM = flush;

   // Per-instance views of the outputs so the model can loop over instances.
   logic pcw[3], ifw[3], idw[3], idb[3], exb[3], bsy[3], rv[3];
   logic [63:0] stc[3];
   assign pcw[0] = ia.pc_write; assign ifw[0] = ia.if_id_write; assign idw[0] = ia.id_ex_write;
   assign idb[0] = ia.id_ex_bubble; assign exb[0] = ia.ex_mem_bubble; assign bsy[0] = ia.mult_busy;
   assign rv[0] = ia.mult_result_valid; assign stc[0] = 64'(ia.stall_cycles);
   assign pcw[1] = ib.pc_write; assign ifw[1] = ib.if_id_write; assign idw[1] = ib.id_ex_write;
   assign idb[1] = ib.id_ex_bubble; assign exb[1] = ib.ex_mem_bubble; assign bsy[1] = ib.mult_busy;
   assign rv[1] = ib.mult_result_valid; assign stc[1] = 64'(ib.stall_cycles);
   assign pcw[2] = ic.pc_write; assign ifw[2] = ic.if_id_write; assign idw[2] = ic.id_ex_write;
   assign idb[2] = ic.id_ex_bubble; assign exb[2] = ic.ex_mem_bubble; assign bsy[2] = ic.mult_busy;
   assign rv[2] = ic.mult_result_valid; assign stc[2] = 64'(ic.stall_cycles);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state: EX cycles already spent by the in-flight multiply (0 = none)
   // and the expected stall counter.
   int          lat[3] = '{4, 2, 1};
   int          wid[3] = '{32, 4, 8};
   int          age[3] = '{0, 0, 0};
   logic [63:0] mst[3] = '{64'd0, 64'd0, 64'd0};

   // Compare process: evaluate the rules on the inputs held for this cycle.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         logic e_pc, e_if, e_id, e_idb, e_exb, e_bsy, e_rv, lu;
         logic [63:0] e_st, n_st, maxv;
         int k, n_age;
         e_pc = 1'b1; e_if = 1'b1; e_id = 1'b1; e_idb = 1'b0; e_exb = 1'b0;
         e_bsy = 1'b0; e_rv = 1'b0; n_age = 0;
         maxv = (64'd1 << wid[i]) - 64'd1;
         lu = mrd && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
         if (rst) begin
            e_st = 64'd0; n_st = 64'd0;
         end else begin
            e_st  = mst[i];
            e_bsy = (age[i] > 0);
            if (flush) begin
               e_idb = 1'b1; e_exb = 1'b1;
            end else begin
               k = (age[i] > 0) ? age[i] : (mul ? 1 : 0);
               if (k > 0 && k < lat[i]) begin
                  e_pc = 1'b0; e_if = 1'b0; e_id = 1'b0; e_exb = 1'b1;
                  n_age = k + 1;
               end else if (k == lat[i]) begin
                  e_rv = 1'b1;
               end else if (lu) begin
                  e_pc = 1'b0; e_if = 1'b0; e_idb = 1'b1;
               end
            end
            n_st = (!e_pc && mst[i] != maxv) ? mst[i] + 64'd1 : mst[i];
         end
         chk($sformatf("pc_write[%0d]", i), 64'(pcw[i]), 64'(e_pc));
         chk($sformatf("if_id_write[%0d]", i), 64'(ifw[i]), 64'(e_if));
         chk($sformatf("id_ex_write[%0d]", i), 64'(idw[i]), 64'(e_id));
         chk($sformatf("id_ex_bubble[%0d]", i), 64'(idb[i]), 64'(e_idb));
         chk($sformatf("ex_mem_bubble[%0d]", i), 64'(exb[i]), 64'(e_exb));
         chk($sformatf("mult_busy[%0d]", i), 64'(bsy[i]), 64'(e_bsy));
         chk($sformatf("mult_result_valid[%0d]", i), 64'(rv[i]), 64'(e_rv));
         chk($sformatf("stall_cycles[%0d]", i), stc[i], e_st);
         age[i] = n_age;
         mst[i] = n_st;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; u1 = 1'b0; u2 = 1'b0;
      mrd = 1'b0; mul = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
   endtask

   initial begin
      idle_inputs();
      #2;
      chk("reset_pc_write", 64'(ia.pc_write), 64'd1);
      chk("reset_id_ex_write", 64'(ia.id_ex_write), 64'd1);
      chk("reset_stall", 64'(ia.stall_cycles), 64'd0);
      step();
      do_reset();

      // Single multiply on the latency-4 instance.
      mul = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         #1;
         chk($sformatf("mul_pc_c%0d", c), 64'(ia.pc_write), (c == 4) ? 64'd1 : 64'd0);
         chk($sformatf("mul_rv_c%0d", c), 64'(ia.mult_result_valid), (c == 4) ? 64'd1 : 64'd0);
         chk($sformatf("mul_busy_c%0d", c), 64'(ia.mult_busy), (c >= 2) ? 64'd1 : 64'd0);
         step();
      end
      mul = 1'b0;
      chk("mul_stall_total", 64'(ia.stall_cycles), 64'd3);

      // Load-use detection and its two non-hazard variants.
      do_reset();
      mrd = 1'b1; rd = 5'd5; rs2 = 5'd5; u2 = 1'b1; #1;
      chk("lu_pc", 64'(ia.pc_write), 64'd0);
      chk("lu_bubble", 64'(ia.id_ex_bubble), 64'd1);
      step();
      rd = 5'd0; rs2 = 5'd0; #1;
      chk("lu_rd0_pc", 64'(ia.pc_write), 64'd1);
      step();
      rd = 5'd5; rs2 = 5'd5; u2 = 1'b0; #1;
      chk("lu_nouse_pc", 64'(ia.pc_write), 64'd1);
      step();
      idle_inputs();
      chk("lu_stall_total", 64'(ia.stall_cycles), 64'd1);

      // Back-to-back multiplies.
      do_reset();
      mul = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         #1;
         chk($sformatf("b2b_rv_c%0d", c), 64'(ia.mult_result_valid),
             (c == 4 || c == 8) ? 64'd1 : 64'd0);
         step();
      end
      mul = 1'b0;
      chk("b2b_stall_total", 64'(ia.stall_cycles), 64'd6);

      // Flush in cycle 2 of a multiply.
      do_reset();
      mul = 1'b1; step();
      flush = 1'b1; #1;
      chk("fl_pc", 64'(ia.pc_write), 64'd1);
      chk("fl_exb", 64'(ia.ex_mem_bubble), 64'd1);
      chk("fl_idb", 64'(ia.id_ex_bubble), 64'd1);
      step();
      flush = 1'b0; mul = 1'b0; #1;
      chk("fl_after_busy", 64'(ia.mult_busy), 64'd0);
      chk("fl_after_rv", 64'(ia.mult_result_valid), 64'd0);
      step();

      // Reset in cycle 3 of a multiply, then a fresh sequence.
      do_reset();
      mul = 1'b1; step(); step();
      rst = 1'b1; #1;
      chk("rst_mid_pc", 64'(ia.pc_write), 64'd1);
      chk("rst_mid_stall", 64'(ia.stall_cycles), 64'd0);
      chk("rst_mid_busy", 64'(ia.mult_busy), 64'd0);
      step();
      rst = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         #1;
         chk($sformatf("rst_fresh_pc_c%0d", c), 64'(ia.pc_write), (c == 4) ? 64'd1 : 64'd0);
         step();
      end
      mul = 1'b0;
      chk("rst_fresh_stall", 64'(ia.stall_cycles), 64'd3);

      // Saturation of the 4-bit counter under continuous multiplies.
      do_reset();
      mul = 1'b1;
      repeat (40) step();
      mul = 1'b0;
      chk("sat_b", 64'(ib.stall_cycles), 64'd15);
      chk("sat_c", 64'(ic.stall_cycles), 64'd0);

      // Randomized traffic, checked by the compare process.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rs1 = 5'($urandom_range(0, 3));
         rs2 = 5'($urandom_range(0, 3));
         rd  = 5'($urandom_range(0, 3));
         u1  = 1'($urandom_range(0, 1));
         u2  = 1'($urandom_range(0, 1));
         mul = ($urandom_range(0, 2) == 0);
         mrd = !mul && ($urandom_range(0, 1) == 1);
         flush = ($urandom_range(0, 15) == 0);
         rst   = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0;
      idle_inputs();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
